calc_btn_enc: RTL and testbench

CALC_BTN_ENC -- requirements
Module: calc_btn_enc

---
 rtl/calc_pkg.sv | 28 ++
 rtl/calc_debounce.sv | 32 +++
 rtl/calc_btn_enc.sv | 107 ++++++++++
 tb/tb_calc_btn_enc.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and the button-chord to ALU-operation encoding for the calculator front end.
package calc_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHORD = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    // mask bit order is {l, c, r}
    function automatic logic [ALU_OP_W-1:0] enc_op(input logic [2:0] mask);
        logic [ALU_OP_W-1:0] op;
        case (mask)
            3'b001:  op = 4'b0001;
            3'b010:  op = 4'b0010;
            3'b011:  op = 4'b0110;
            3'b100:  op = 4'b0100;
            3'b101:  op = 4'b1001;
            3'b110:  op = 4'b1010;
            3'b111:  op = 4'b0101;
            default: op = 4'b0000;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/calc_debounce.sv
// Single-bit debouncer: the output follows the input only after it has disagreed
// for DB_CYCLES consecutive cycles.
module calc_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            // this is the DB_CYCLES-th disagreeing cycle
            cnt  <= '0;
            dout <= din;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/calc_btn_enc.sv
// Three push-buttons -> synchronise, debounce, collect a chord, and emit one
// encoded ALU operation with a single-cycle strobe once all buttons are released.
module calc_btn_enc
    import calc_pkg::*;
#(
    parameter int DB_CYCLES   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btnl,
    input  logic                btnc,
    input  logic                btnr,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                op_valid,
    output logic                busy
);

    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0]                  deb;
    state_t                      state, state_next;
    logic [2:0]                  mask, mask_next;
    logic                        emit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {btnl, btnc, btnr};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    calc_debounce #(.DB_CYCLES(DB_CYCLES)) u_deb_l (
        .clk  (clk),
        .rst  (rst),
        .din  (sync_q[SYNC_STAGES-1][2]),
        .dout (deb[2])
    );

    calc_debounce #(.DB_CYCLES(DB_CYCLES)) u_deb_c (
        .clk  (clk),
        .rst  (rst),
        .din  (sync_q[SYNC_STAGES-1][1]),
        .dout (deb[1])
    );

    calc_debounce #(.DB_CYCLES(DB_CYCLES)) u_deb_r (
        .clk  (clk),
        .rst  (rst),
        .din  (sync_q[SYNC_STAGES-1][0]),
        .dout (deb[0])
    );

    always_comb begin
        state_next = state;
        mask_next  = mask;
        emit       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|deb) begin
                    state_next = ST_CHORD;
                    mask_next  = deb;
                end
            end
            ST_CHORD: begin
                // buttons released early stay in the chord
                mask_next = mask | deb;
                if (deb == 3'b000) begin
                    state_next = ST_EMIT;
                    emit       = 1'b1;
                end
            end
            ST_EMIT: begin
                // a press already visible here is picked up from IDLE next cycle
                state_next = ST_IDLE;
                mask_next  = 3'b000;
            end
            default: begin
                state_next = ST_IDLE;
                mask_next  = 3'b000;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            mask     <= 3'b000;
            alu_op   <= '0;
            op_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            mask     <= mask_next;
            op_valid <= emit;
            busy     <= (state_next != ST_IDLE);
            if (emit) begin
                alu_op <= enc_op(mask_next);
            end
        end
    end

endmodule

// File: tb/tb_calc_btn_enc.sv
// Directed bench for calc_btn_enc with DB_CYCLES=4, SYNC_STAGES=2.
module tb_calc_btn_enc;

    logic       clk;
    logic       rst;
    logic       btnl;
    logic       btnc;
    logic       btnr;
    logic [3:0] alu_op;
    logic       op_valid;
    logic       busy;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         pulse_cnt = 0;
    logic [3:0] ops[$];

    calc_btn_enc #(.DB_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .btnl     (btnl),
        .btnc     (btnc),
        .btnr     (btnr),
        .alu_op   (alu_op),
        .op_valid (op_valid),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every strobe so pulse counts and sequences can be checked afterwards.
    always @(negedge clk) begin
        if (op_valid) begin
            pulse_cnt <= pulse_cnt + 1;
            ops.push_back(alu_op);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int bound, output bit found, output int lat,
                              output logic [3:0] op, output logic bsy);
        found = 1'b0;
        lat   = 0;
        op    = '0;
        bsy   = 1'b0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (op_valid) begin
                found = 1'b1;
                lat   = i;
                op    = alu_op;
                bsy   = busy;
                break;
            end
        end
    endtask

    initial begin
        bit         found;
        int         lat;
        int         base;
        int         bad;
        logic [3:0] op;
        logic       bsy;
        logic       busy7;
        logic       busy8;

        rst  = 1'b1;
        btnl = 1'b0;
        btnc = 1'b0;
        btnr = 1'b0;
        tick(3);
        check("rst_alu_op", 32'(alu_op), 'h0);
        check("rst_op_valid", 32'(op_valid), 'h0);
        check("rst_busy", 32'(busy), 'h0);
        rst = 1'b0;
        tick(5);

        // single tap on r: release-to-strobe is 2 sync + 4 debounce + 1 FSM cycles
        base = pulse_cnt;
        btnr = 1'b1;
        tick(20);
        btnr = 1'b0;
        wait_pulse(40, found, lat, op, bsy);
        check("tap_found", 32'(found), 'h1);
        check("tap_latency", 32'(lat), 'd8);
        check("tap_op", 32'(op), 'h1);
        check("tap_busy_emit", 32'(bsy), 'h1);
        @(negedge clk);
        check("tap_busy_after", 32'(busy), 'h0);
        check("tap_valid_after", 32'(op_valid), 'h0);
        tick(5);
        check("tap_pulses", 32'(pulse_cnt - base), 'd1);

        // staggered l then r, l released first
        base = pulse_cnt;
        btnl = 1'b1;
        tick(5);
        btnr = 1'b1;
        tick(10);
        btnl = 1'b0;
        tick(10);
        btnr = 1'b0;
        wait_pulse(40, found, lat, op, bsy);
        check("stag_found", 32'(found), 'h1);
        check("stag_op", 32'(op), 'h9);
        tick(10);
        check("stag_pulses", 32'(pulse_cnt - base), 'd1);

        // bouncing c: runs of 2 never settle, then a clean hold
        base = pulse_cnt;
        for (int i = 0; i < 15; i++) begin
            btnc = (i % 2 == 0);
            tick(2);
        end
        btnc = 1'b1;
        tick(20);
        btnc = 1'b0;
        wait_pulse(40, found, lat, op, bsy);
        check("bounce_found", 32'(found), 'h1);
        check("bounce_op", 32'(op), 'h2);
        tick(10);
        check("bounce_pulses", 32'(pulse_cnt - base), 'd1);

        // 3-cycle glitch is shorter than the debounce window
        base = pulse_cnt;
        btnc = 1'b1;
        tick(3);
        btnc = 1'b0;
        tick(20);
        check("glitch_pulses", 32'(pulse_cnt - base), 'd0);
        check("glitch_busy", 32'(busy), 'h0);

        // all three, then alu_op must hold through a long idle stretch
        base = pulse_cnt;
        btnl = 1'b1;
        btnc = 1'b1;
        btnr = 1'b1;
        tick(15);
        btnl = 1'b0;
        btnc = 1'b0;
        btnr = 1'b0;
        wait_pulse(40, found, lat, op, bsy);
        check("all3_found", 32'(found), 'h1);
        check("all3_op", 32'(op), 'h5);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (op_valid || alu_op != 4'b0101) bad++;
        end
        check("all3_hold_bad", 32'(bad), 'd0);
        check("all3_hold_op", 32'(alu_op), 'h5);
        check("all3_pulses", 32'(pulse_cnt - base), 'd1);

        // reset in the middle of an l+c chord
        tick(1);
        btnl = 1'b1;
        btnc = 1'b1;
        tick(12);
        check("chord_busy", 32'(busy), 'h1);
        base = pulse_cnt;
        rst = 1'b1;
        #1;
        check("midrst_alu_op", 32'(alu_op), 'h0);
        check("midrst_busy", 32'(busy), 'h0);
        check("midrst_valid", 32'(op_valid), 'h0);
        tick(3);
        btnl = 1'b0;
        btnc = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(30);
        check("midrst_op_after", 32'(alu_op), 'h0);
        check("midrst_pulses", 32'(pulse_cnt - base), 'd0);

        // r held through reset is seen after the normal latency once reset lifts
        btnr = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(5);
        rst = 1'b0;
        busy7 = 1'b0;
        busy8 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 7) busy7 = busy;
            if (i == 8) busy8 = busy;
        end
        check("held_busy_c7", 32'(busy7), 'h0);
        check("held_busy_c8", 32'(busy8), 'h1);
        tick(5);
        btnr = 1'b0;
        wait_pulse(40, found, lat, op, bsy);
        check("held_found", 32'(found), 'h1);
        check("held_op", 32'(op), 'h1);

        // back-to-back: c's debounced rise lands on the EMIT cycle of the l chord
        tick(5);
        base = pulse_cnt;
        btnl = 1'b1;
        tick(10);
        btnl = 1'b0;
        tick(1);
        btnc = 1'b1;
        tick(10);
        btnc = 1'b0;
        tick(30);
        check("b2b_pulses", 32'(pulse_cnt - base), 'd2);
        if (pulse_cnt >= base + 2) begin
            check("b2b_first_op", 32'(ops[base]), 'h4);
            check("b2b_second_op", 32'(ops[base+1]), 'h2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
